idli_sqi_mem_m: RTL and testbench
=================================

IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning the number of storage bytes; it is a power of two, 2..65536.
REQ-002 The block SHALL have port i_mem_gck, input, 1 bit: the single clock, equal to the SQI serial clock; all logic uses its rising edge.
REQ-003 The block SHALL have port i_mem_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port i_mem_cs, input, 1 bit: chip select, active low; 1 means idle.
REQ-005 The block SHALL have port i_mem_sio, input, 4 bits: quad data from the initiator.
REQ-006 The block SHALL have port o_mem_sio, output, 4 bits: quad read data to the initiator.
REQ-007 The block SHALL have port o_mem_sio_oe, output, 1 bit: 1 means the responder drives the SQI bus.

Function
REQ-008 The block SHALL be the SQI memory responder for the idli core, implementing sequential READ (0x03) and WRITE (0x02) in quad mode only.
REQ-009 Edges SHALL be numbered from 1 at the first rising edge with i_mem_cs=0 after i_mem_cs was 1 or after reset.
REQ-010 All nibble fields SHALL be sampled from i_mem_sio most-significant nibble first.
REQ-011 The instruction byte SHALL be captured at edges 1-2 and a 16-bit address at edges 3-6.
REQ-012 Address bits SHALL be used modulo DEPTH; unused upper bits are ignored.
REQ-013 State machine states: INSTR, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE.
REQ-014 Transitions: INSTR->ADDR after edge 2 when the instruction is 0x02 or 0x03; otherwise INSTR->IGNORE.
REQ-015 ADDR->DUMMY after edge 6 for READ; ADDR->WR_DATA after edge 6 for WRITE.
REQ-016 DUMMY->RD_DATA after edge 8.
REQ-017 RD_DATA, WR_DATA and IGNORE SHALL be held until i_mem_cs=1.
REQ-018 Any rising edge sampling i_mem_cs=1 SHALL force INSTR and clear the nibble counter and the partial byte, regardless of state.
REQ-019 READ: i_mem_sio SHALL be ignored at edges 7-8 (dummy byte).
REQ-020 READ output: after edge 8, o_mem_sio SHALL register the high nibble of mem[A]; after edge 9 the low nibble of mem[A]; after edge 10 the high nibble of mem[A+1]; the pattern continues one nibble per edge.
REQ-021 READ: o_mem_sio_oe SHALL be 1 from edge 8 until i_mem_cs=1.
REQ-022 o_mem_sio_oe SHALL be forced to 0 combinationally while i_mem_cs=1.
REQ-023 WRITE: the high nibble SHALL be captured at edge 7 and mem[A] written at edge 8; mem[A+1] is captured at edges 9-10, and so on.
REQ-024 A write byte SHALL be stored only when both of its nibbles have been sampled; a half byte at deselect is discarded.
REQ-025 The byte address SHALL increment by 1 after each completed byte and wrap from DEPTH-1 to 0.
REQ-026 o_mem_sio SHALL be 4'b0000 whenever o_mem_sio_oe=0.
REQ-027 In IGNORE, no memory write SHALL occur and o_mem_sio_oe SHALL be 0.
REQ-028 The nibble counter SHALL saturate once the data phase is reached, so bursts of any length are allowed.

Reset
REQ-029 Asserting i_mem_rst_n=0 SHALL, asynchronously: set state to INSTR, clear the counters, address and partial byte, set o_mem_sio_oe=0 and set o_mem_sio=0.
REQ-030 Reset asserted mid-operation SHALL abort the transaction; a half-written byte is not stored.
REQ-031 Memory contents SHALL NOT be reset; the value of unwritten bytes is undefined and is not checked by the bench.
REQ-032 After reset is released, the first transaction SHALL begin at edge 1 of the next i_mem_cs=0 period.

Verification
REQ-033 WRITE A=0x0010 with data 0xA5,0x3C, then deselect; READ A=0x0010 -> nibbles A,5,3,C after edges 8-11, with oe rising after edge 8.
REQ-034 With DEPTH=256: WRITE A=0x00FF with data 0x11,0x22; READ A=0x0000 -> 0x22; READ A=0x00FF -> 0x11; READ A=0x01FF -> 0x11 (upper bits ignored).
REQ-035 Instruction 0x05 followed by 8 nibbles -> oe=0 throughout and no memory change, checked by reading back the prior contents.
REQ-036 WRITE A=0x0020 with data 0x77, then a third nibble 0xF and deselect -> mem[0x20]=0x77 and mem[0x21] unchanged.
REQ-037 Deselect at edge 4 of a READ, then a new WRITE A=0x0030 with data 0x5A -> the write completes normally; a later READ of 0x30 returns 0x5A.
REQ-038 Assert reset during a READ data phase -> oe=0 and sio=0 immediately (asynchronously); the next READ returns correct data.

Source files
------------

// File: rtl/idli_sqi_mem_m.sv
// SQI quad-mode memory responder for the idli core.
// Supports sequential READ (0x03) and WRITE (0x02) with a 16-bit address.
module idli_sqi_mem_m #(
    parameter int unsigned DEPTH = 256
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst_n,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [7:0] InstrWrite = 8'h02;
    localparam logic [7:0] InstrRead  = 8'h03;

    typedef enum logic [2:0] {
        StInstr,
        StAddr,
        StDummy,
        StRdData,
        StWrData,
        StIgnore
    } state_e;

    state_e          state_q;
    logic [3:0]      cnt_q;
    logic [11:0]     shift_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      hold_q;
    logic            half_q;
    logic            is_read_q;
    logic            oe_q;
    logic [3:0]      sio_q;

    logic [7:0]      mem [DEPTH];

    logic [7:0]      instr;
    logic [15:0]     addr_full;
    logic [7:0]      rd_byte;
    logic            wr_en;
    logic            unused_addr_bits;

    always_comb begin
        instr            = {shift_q[3:0], i_mem_sio};
        addr_full        = {shift_q, i_mem_sio};
        rd_byte          = mem[addr_q];
        wr_en            = !i_mem_cs && (state_q == StWrData) && half_q;
        // Upper address bits beyond DEPTH are deliberately discarded.
        unused_addr_bits = ^addr_full;
    end

    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q   <= StInstr;
            cnt_q     <= 4'd0;
            shift_q   <= 12'd0;
            addr_q    <= '0;
            hold_q    <= 4'd0;
            half_q    <= 1'b0;
            is_read_q <= 1'b0;
            oe_q      <= 1'b0;
            sio_q     <= 4'd0;
        end else if (i_mem_cs) begin
            state_q <= StInstr;
            cnt_q   <= 4'd0;
            shift_q <= 12'd0;
            hold_q  <= 4'd0;
            half_q  <= 1'b0;
            oe_q    <= 1'b0;
            sio_q   <= 4'd0;
        end else begin
            shift_q <= {shift_q[7:0], i_mem_sio};
            // Counter only advances through the header, so data bursts are unbounded.
            if (state_q == StInstr || state_q == StAddr || state_q == StDummy) begin
                cnt_q <= cnt_q + 4'd1;
            end
            unique case (state_q)
                StInstr: begin
                    if (cnt_q == 4'd1) begin
                        if (instr == InstrWrite || instr == InstrRead) begin
                            state_q   <= StAddr;
                            is_read_q <= (instr == InstrRead);
                        end else begin
                            state_q <= StIgnore;
                        end
                    end
                end
                StAddr: begin
                    if (cnt_q == 4'd5) begin
                        addr_q  <= addr_full[AW-1:0];
                        state_q <= is_read_q ? StDummy : StWrData;
                    end
                end
                StDummy: begin
                    if (cnt_q == 4'd7) begin
                        sio_q   <= rd_byte[7:4];
                        oe_q    <= 1'b1;
                        half_q  <= 1'b1;
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (half_q) begin
                        sio_q  <= rd_byte[3:0];
                        addr_q <= addr_q + AW'(1);
                        half_q <= 1'b0;
                    end else begin
                        sio_q  <= rd_byte[7:4];
                        half_q <= 1'b1;
                    end
                end
                StWrData: begin
                    if (half_q) begin
                        addr_q <= addr_q + AW'(1);
                        half_q <= 1'b0;
                    end else begin
                        hold_q <= i_mem_sio;
                        half_q <= 1'b1;
                    end
                end
                StIgnore: begin
                    state_q <= StIgnore;
                end
                default: begin
                    state_q <= StInstr;
                end
            endcase
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge i_mem_gck) begin
        if (wr_en) begin
            mem[addr_q] <= {hold_q, i_mem_sio};
        end
    end

    always_comb begin
        o_mem_sio_oe = oe_q && !i_mem_cs;
        o_mem_sio    = o_mem_sio_oe ? sio_q : 4'd0;
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed self-checking bench for the SQI memory responder.
module tb_idli_sqi_mem_m;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cs = 1'b1;
    logic [3:0] sio_in = 4'd0;
    logic [3:0] sio_out;
    logic       oe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    idli_sqi_mem_m #(.DEPTH(256)) dut (
        .i_mem_gck   (clk),
        .i_mem_rst_n (rst_n),
        .i_mem_cs    (cs),
        .i_mem_sio   (sio_in),
        .o_mem_sio   (sio_out),
        .o_mem_sio_oe(oe)
    );

    task automatic send_nib(input logic [3:0] n);
        @(negedge clk);
        cs     = 1'b0;
        sio_in = n;
    endtask

    task automatic deselect();
        @(negedge clk);
        cs     = 1'b1;
        sio_in = 4'd0;
        @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] ins, input logic [15:0] a);
        send_nib(ins[7:4]);
        send_nib(ins[3:0]);
        for (int i = 0; i < 4; i++) send_nib(a[15-4*i -: 4]);
    endtask

    task automatic write_bytes(input logic [15:0] a, input logic [7:0] d [4], input int n);
        send_hdr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            send_nib(d[i][7:4]);
            send_nib(d[i][3:0]);
        end
        deselect();
    endtask

    // Leaves CS asserted so callers can interrupt the data phase.
    task automatic read_nibs(input logic [15:0] a, input int n, output logic oe_pre,
                             output logic [3:0] nib [8], output logic oe_v [8]);
        send_hdr(8'h03, a);
        send_nib(4'h0);
        @(negedge clk);
        oe_pre = oe;
        sio_in = 4'h0;
        for (int k = 0; k < 8; k++) begin
            nib[k]  = 4'h0;
            oe_v[k] = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            nib[k]  = sio_out;
            oe_v[k] = oe;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (oe !== 1'b0) begin
            errors++; $display("FAIL reset_oe got %b expected 0", oe);
        end
        checks++;
        if (sio_out !== 4'h0) begin
            errors++; $display("FAIL reset_sio got %h expected 0", sio_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        logic [3:0] exp [4];
        exp = '{4'hA, 4'h5, 4'h3, 4'hC};
        write_bytes(16'h0010, '{8'hA5, 8'h3C, 8'h00, 8'h00}, 2);
        read_nibs(16'h0010, 4, pre, nib, oev);
        checks++;
        if (pre !== 1'b0) begin
            errors++; $display("FAIL basic_oe_edge7 got %b expected 0", pre);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (nib[k] !== exp[k] || oev[k] !== 1'b1) begin
                errors++;
                $display("FAIL basic_nib%0d got %h/oe%b expected %h/oe1", k, nib[k], oev[k], exp[k]);
            end
        end
        @(negedge clk);
        cs = 1'b1;
        #1;
        checks++;
        if (oe !== 1'b0 || sio_out !== 4'h0) begin
            errors++; $display("FAIL basic_deselect_oe got %b/%h expected 0/0", oe, sio_out);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [3:0]  nib [8];
        logic        oev [8];
        logic        pre;
        logic [15:0] addrs [4];
        logic [7:0]  exp [4];
        addrs = '{16'h0000, 16'h00FF, 16'h01FF, 16'hFFFF};
        exp   = '{8'h22, 8'h11, 8'h11, 8'h11};
        write_bytes(16'h00FF, '{8'h11, 8'h22, 8'h00, 8'h00}, 2);
        for (int i = 0; i < 4; i++) begin
            read_nibs(addrs[i], 2, pre, nib, oev);
            checks++;
            if ({nib[0], nib[1]} !== exp[i]) begin
                errors++;
                $display("FAIL wrap_read_%h got %h expected %h", addrs[i], {nib[0], nib[1]}, exp[i]);
            end
            deselect();
        end
        read_nibs(16'h00FF, 4, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1], nib[2], nib[3]} !== 16'h1122) begin
            errors++;
            $display("FAIL wrap_burst got %h expected 1122", {nib[0], nib[1], nib[2], nib[3]});
        end
        deselect();
    endtask

    task automatic test_ignore();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        logic [3:0] seq [10];
        int         bad;
        seq = '{4'h0, 4'h5, 4'h0, 4'h0, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (oe !== 1'b0 || sio_out !== 4'h0) bad++;
            cs     = 1'b0;
            sio_in = seq[i];
        end
        @(negedge clk);
        if (oe !== 1'b0 || sio_out !== 4'h0) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL ignore_oe got %0d driven samples expected 0", bad);
        end
        deselect();
        read_nibs(16'h0010, 4, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1], nib[2], nib[3]} !== 16'hA53C) begin
            errors++;
            $display("FAIL ignore_mem got %h expected a53c", {nib[0], nib[1], nib[2], nib[3]});
        end
        deselect();
    endtask

    task automatic test_half_byte();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        write_bytes(16'h0021, '{8'h9C, 8'h00, 8'h00, 8'h00}, 1);
        send_hdr(8'h02, 16'h0020);
        send_nib(4'h7);
        send_nib(4'h7);
        send_nib(4'hF);
        deselect();
        read_nibs(16'h0020, 4, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1], nib[2], nib[3]} !== 16'h779C) begin
            errors++;
            $display("FAIL half_byte got %h expected 779c", {nib[0], nib[1], nib[2], nib[3]});
        end
        deselect();
    endtask

    task automatic test_abort_read();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        send_nib(4'h0);
        send_nib(4'h3);
        send_nib(4'h0);
        send_nib(4'h0);
        deselect();
        write_bytes(16'h0030, '{8'h5A, 8'h00, 8'h00, 8'h00}, 1);
        read_nibs(16'h0030, 2, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1]} !== 8'h5A) begin
            errors++; $display("FAIL abort_read got %h expected 5a", {nib[0], nib[1]});
        end
        deselect();
    endtask

    task automatic test_reset_mid();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        write_bytes(16'h0040, '{8'hC3, 8'h96, 8'h00, 8'h00}, 2);
        write_bytes(16'h0050, '{8'h12, 8'h00, 8'h00, 8'h00}, 1);
        read_nibs(16'h0040, 2, pre, nib, oev);
        checks++;
        if (oev[1] !== 1'b1 || {nib[0], nib[1]} !== 8'hC3) begin
            errors++;
            $display("FAIL rstmid_pre got %h/oe%b expected c3/oe1", {nib[0], nib[1]}, oev[1]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (oe !== 1'b0 || sio_out !== 4'h0) begin
            errors++; $display("FAIL rstmid_async got %b/%h expected 0/0", oe, sio_out);
        end
        @(negedge clk);
        cs    = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        read_nibs(16'h0040, 4, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1], nib[2], nib[3]} !== 16'hC396) begin
            errors++;
            $display("FAIL rstmid_after got %h expected c396", {nib[0], nib[1], nib[2], nib[3]});
        end
        deselect();
        send_hdr(8'h02, 16'h0050);
        send_nib(4'hE);
        @(negedge clk);
        sio_in = 4'hF;
        #2 rst_n = 1'b0;
        @(negedge clk);
        cs    = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        read_nibs(16'h0050, 2, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1]} !== 8'h12) begin
            errors++; $display("FAIL rstmid_halfwrite got %h expected 12", {nib[0], nib[1]});
        end
        deselect();
    endtask

    task automatic test_back_to_back();
        logic [3:0] nib [8];
        logic       oev [8];
        logic       pre;
        write_bytes(16'h0060, '{8'h01, 8'hEF, 8'h7B, 8'h42}, 4);
        read_nibs(16'h0060, 8, pre, nib, oev);
        checks++;
        if ({nib[0], nib[1], nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]} !== 32'h01EF7B42) begin
            errors++;
            $display("FAIL burst4 got %h expected 01ef7b42",
                     {nib[0], nib[1], nib[2], nib[3], nib[4], nib[5], nib[6], nib[7]});
        end
        deselect();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_ignore();
        test_half_byte();
        test_abort_read();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
